// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer and clock-enable generator for the single-cycle MIPS core.
// Single-step support (step_mode port, STEP state) is compiled in with `define CPU_SINGLE_STEP_EN.
module cpu_run_ctrl #(
  parameter int unsigned DIV1  = 1000,
  parameter int unsigned DIV2  = 100000,
  parameter int unsigned DIV3  = 10000000,
  parameter int unsigned CNT_W = 24
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        go,
  input  logic [1:0]  hz,
  input  logic        halt_req,
`ifdef CPU_SINGLE_STEP_EN
  input  logic        step_mode,
`endif
  output logic        cpu_ce,
  output logic        clk_N,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] icount
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;
  localparam logic [1:0] ST_STEP = 2'b11;

  logic             go_s1;
  logic             go_s2;
  logic             go_s3;
  logic             go_pe;
  logic [1:0]       hz_q;
  logic             hz_chg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] lim_m1;
  logic             tick;
  logic [1:0]       state_nxt;
  logic             ce_nxt;
  logic             step_sel;

`ifdef CPU_SINGLE_STEP_EN
  assign step_sel = step_mode;
`else
  assign step_sel = 1'b0;
`endif

  // Go button: two-flop synchronizer, then a one-clk rising-edge pulse
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      go_s1 <= 1'b0;
      go_s2 <= 1'b0;
      go_s3 <= 1'b0;
    end else begin
      go_s1 <= go;
      go_s2 <= go_s1;
      go_s3 <= go_s2;
    end
  end

  assign go_pe = go_s2 & ~go_s3;

  // Divider terminal count from the registered rate select
  always_comb begin
    lim_m1 = '0;
    case (hz_q)
      2'd0:    lim_m1 = '0;
      2'd1:    lim_m1 = CNT_W'(DIV1 - 1);
      2'd2:    lim_m1 = CNT_W'(DIV2 - 1);
      default: lim_m1 = CNT_W'(DIV3 - 1);
    endcase
  end

  assign hz_chg = (hz != hz_q);
  assign tick   = (cnt == lim_m1) & ~hz_chg;
  assign halted = (state == ST_IDLE) || (state == ST_HALT);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    ce_nxt    = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (go_pe) begin
          state_nxt = step_sel ? ST_STEP : ST_RUN;
          ce_nxt    = step_sel;
        end
      end
      ST_RUN: begin
        // The halting instruction retires this cycle; a coincident go_pe is dropped
        if (cpu_ce && halt_req) begin
          state_nxt = ST_HALT;
        end else begin
          ce_nxt  = tick;
          cnt_nxt = (tick || hz_chg) ? '0 : cnt + CNT_W'(1);
        end
      end
      ST_STEP: begin
        state_nxt = ST_HALT;
      end
    endcase
  end

  // Divider, rate register and retired-instruction bookkeeping
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt    <= '0;
      hz_q   <= 2'b00;
      cpu_ce <= 1'b0;
      clk_N  <= 1'b0;
      icount <= 32'd0;
    end else begin
      cnt    <= cnt_nxt;
      hz_q   <= hz;
      cpu_ce <= ce_nxt;
      if (cpu_ce) begin
        clk_N  <= ~clk_N;
        icount <= icount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: bring-up vector table, directed corner sequences,
// and randomized stimulus against a schedule-based reference model.
module tb_cpu_run_ctrl;

  localparam int unsigned DIV1 = 4;
  localparam int unsigned DIV2 = 10;
  localparam int unsigned DIV3 = 16;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;
  localparam logic [1:0] S_STEP = 2'b11;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        go;
  logic [1:0]  hz;
  logic        halt_req;
  logic        step_mode;
  logic        cpu_ce;
  logic        clk_N;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] icount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        go;
    logic [1:0]  hz;
    logic        halt_req;
    logic [1:0]  st;
    logic        ce;
    logic [31:0] ic;
    logic        clkn;
  } vec_t;

  vec_t tbl [14];

  // Reference model: mode plus the absolute cycle at which the next enable is due
  logic [1:0]  m_mode;
  logic        m_ce;
  logic        m_clkn;
  logic [31:0] m_ic;
  logic [1:0]  m_hz;
  logic        g_hist [4];
  int          ncyc;
  int          next_ce;

  cpu_run_ctrl #(
    .DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3), .CNT_W(24)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .go       (go),
    .hz       (hz),
    .halt_req (halt_req),
`ifdef CPU_SINGLE_STEP_EN
    .step_mode(step_mode),
`endif
    .cpu_ce   (cpu_ce),
    .clk_N    (clk_N),
    .halted   (halted),
    .state    (state),
    .icount   (icount)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lim(input logic [1:0] h);
    case (h)
      2'd0:    return 1;
      2'd1:    return int'(DIV1);
      2'd2:    return int'(DIV2);
      default: return int'(DIV3);
    endcase
  endfunction

  task automatic model_reset();
    m_mode = S_IDLE;
    m_ce   = 1'b0;
    m_clkn = 1'b0;
    m_ic   = 32'd0;
    m_hz   = 2'd0;
    for (int i = 0; i < 4; i++) g_hist[i] = 1'b0;
    ncyc    = 0;
    next_ce = 0;
  endtask

  task automatic model_edge();
    logic pe;
    logic cew;
    logic hzc;
    g_hist[3] = g_hist[2];
    g_hist[2] = g_hist[1];
    g_hist[1] = g_hist[0];
    g_hist[0] = go;
    pe  = g_hist[2] & ~g_hist[3];
    cew = m_ce;
    m_ce = 1'b0;
    if (cew) begin
      m_ic   = m_ic + 32'd1;
      m_clkn = ~m_clkn;
    end
    hzc  = (hz != m_hz);
    m_hz = hz;
    ncyc++;
    case (m_mode)
      S_IDLE, S_HALT: begin
        if (pe) begin
          if (step_mode) begin
            m_mode = S_STEP;
            m_ce   = 1'b1;
          end else begin
            m_mode  = S_RUN;
            next_ce = ncyc + lim(m_hz);
          end
        end
      end
      S_RUN: begin
        if (cew && halt_req) begin
          m_mode = S_HALT;
        end else if (hzc) begin
          next_ce = ncyc + lim(m_hz);
        end else if (ncyc == next_ce) begin
          m_ce    = 1'b1;
          next_ce = ncyc + lim(m_hz);
        end
      end
      S_STEP: m_mode = S_HALT;
    endcase
  endtask

  // One clock: advance model at the edge, compare all outputs just after it
  task automatic clk_step();
    @(posedge clk);
    model_edge();
    #1;
    check("state",  32'(state),  32'(m_mode));
    check("cpu_ce", 32'(cpu_ce), 32'(m_ce));
    check("icount", icount,      m_ic);
    check("clk_N",  32'(clk_N),  32'(m_clkn));
    check("halted", 32'(halted), 32'((m_mode == S_IDLE) || (m_mode == S_HALT)));
  endtask

  task automatic apply_reset();
    clr_n    = 1'b0;
    go       = 1'b0;
    halt_req = 1'b0;
    #1;
    check("rst_state",  32'(state),  32'(S_IDLE));
    check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    check("rst_icount", icount,      32'd0);
    check("rst_clk_N",  32'(clk_N),  32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    model_reset();
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
  endtask

  task automatic go_pulse();
    go = 1'b1;
    repeat (3) clk_step();
    go = 1'b0;
    repeat (3) clk_step();
  endtask

  initial begin
    int ce_seen;
    int steps_seen;
    int gaps_bad;
    int last;
    logic [31:0] ic0;

    // Bring-up vectors: hz=0, go held 3 clks from row 0
    for (int i = 0; i < 14; i++) begin
      tbl[i].go       = (i < 3);
      tbl[i].hz       = 2'd0;
      tbl[i].halt_req = 1'b0;
      tbl[i].st       = (i >= 2) ? S_RUN : S_IDLE;
      tbl[i].ce       = (i >= 3);
      tbl[i].ic       = (i >= 4) ? 32'(i - 3) : 32'd0;
      tbl[i].clkn     = (i >= 4) ? ((i - 3) % 2 == 1) : 1'b0;
    end

    clr_n = 1'b1; go = 1'b0; hz = 2'd0; halt_req = 1'b0; step_mode = 1'b0;
    #3;
    apply_reset();

    for (int i = 0; i < 14; i++) begin
      go = tbl[i].go; hz = tbl[i].hz; halt_req = tbl[i].halt_req;
      clk_step();
      check($sformatf("vec%0d_state", i),  32'(state),  32'(tbl[i].st));
      check($sformatf("vec%0d_ce", i),     32'(cpu_ce), 32'(tbl[i].ce));
      check($sformatf("vec%0d_icount", i), icount,      tbl[i].ic);
      check($sformatf("vec%0d_clk_N", i),  32'(clk_N),  32'(tbl[i].clkn));
    end

    // Halt on the enable cycle where icount=5, then a quiet HALT and resume
    apply_reset();
    hz = 2'd0;
    go_pulse();
    for (int i = 0; i < 100 && !(cpu_ce === 1'b1 && icount == 32'd5); i++) clk_step();
    check("reach_ic5", {31'd0, cpu_ce} + (icount == 32'd5 ? 32'd0 : 32'd100), 32'd1);
    halt_req = 1'b1;
    clk_step();
    halt_req = 1'b0;
    check("halt_state",  32'(state),  32'(S_HALT));
    check("halt_icount", icount,      32'd6);
    check("halt_ce",     32'(cpu_ce), 32'd0);
    ce_seen = 0;
    repeat (100) begin
      clk_step();
      ce_seen += int'(cpu_ce);
    end
    check("halt_quiet",   32'(ce_seen), 32'd0);
    check("halt_icount2", icount,       32'd6);
    go_pulse();
    check("resume_state", 32'(state), 32'(S_RUN));

    // Halt and go_pe in the same cycle: halt wins, go_pe dropped
    go = 1'b1;
    clk_step();
    clk_step();
    check("simul_ce_pre", 32'(cpu_ce), 32'd1);
    halt_req = 1'b1;
    clk_step();
    halt_req = 1'b0;
    check("simul_state", 32'(state), 32'(S_HALT));
    ce_seen = 0;
    repeat (20) begin
      clk_step();
      ce_seen += int'(cpu_ce);
    end
    go = 1'b0;
    clk_step();
    check("simul_quiet", 32'(ce_seen), 32'd0);
    check("simul_stay",  32'(state),   32'(S_HALT));

    // DIV1 cadence, then a rate change landing exactly on a due tick
    apply_reset();
    hz = 2'd1;
    go_pulse();
    for (int i = 0; i < 20 && cpu_ce !== 1'b1; i++) clk_step();
    check("div1_first", 32'(cpu_ce), 32'd1);
    ic0 = icount; ce_seen = 0; gaps_bad = 0; last = 0;
    for (int k = 1; k <= 40; k++) begin
      clk_step();
      if (cpu_ce) begin
        ce_seen++;
        if (k - last != int'(DIV1)) gaps_bad++;
        last = k;
      end
    end
    check("div1_count",  32'(ce_seen), 32'd10);
    check("div1_icount", icount - ic0, 32'd10);
    check("div1_gap",    32'(gaps_bad), 32'd0);
    repeat (3) clk_step();
    hz = 2'd2;
    for (int k = 0; k <= int'(DIV2); k++) begin
      clk_step();
      check($sformatf("hzchg_ce_k%0d", k), 32'(cpu_ce), 32'(k == int'(DIV2)));
    end
    hz = 2'd0;
    repeat (4) clk_step();
    check("pre_reset_ce", 32'(cpu_ce), 32'd1);
    apply_reset();

`ifdef CPU_SINGLE_STEP_EN
    // Single-step from HALT: one enable per go pulse, back to HALT each time
    hz = 2'd0;
    go_pulse();
    halt_req = 1'b1;
    clk_step();
    halt_req = 1'b0;
    check("step_pre_halt", 32'(state), 32'(S_HALT));
    step_mode = 1'b1;
    ic0 = icount; ce_seen = 0; steps_seen = 0;
    for (int p = 0; p < 3; p++) begin
      go = 1'b1;
      repeat (2) begin
        clk_step();
        ce_seen += int'(cpu_ce);
        if (state == S_STEP && cpu_ce) steps_seen++;
      end
      go = 1'b0;
      repeat (4) begin
        clk_step();
        ce_seen += int'(cpu_ce);
        if (state == S_STEP && cpu_ce) steps_seen++;
      end
      check($sformatf("step%0d_back_halt", p), 32'(state), 32'(S_HALT));
    end
    check("step_ce_count",  32'(ce_seen),    32'd3);
    check("step_state_hit", 32'(steps_seen), 32'd3);
    check("step_icount",    icount - ic0,    32'd3);
    step_mode = 1'b0;
`else
    steps_seen = 0;
`endif

    // Randomized run against the model
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) go = ~go;
      if ($urandom_range(63) == 0) hz = 2'($urandom_range(3));
      halt_req = ($urandom_range(5) == 0);
`ifdef CPU_SINGLE_STEP_EN
      if ($urandom_range(31) == 0) step_mode = ~step_mode;
`endif
      if ($urandom_range(999) == 0) apply_reset();
      clk_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
